// File: rtl/key_expand_seq.sv
// Word-serial AES-128/192/256 key expansion streaming w[0..4*(NK+7)-1] over valid/ready.
// Optional KEXP_BACKPRESSURE_EN honours rk_ready; otherwise one word leaves every RUN cycle.
module byte2S (
  input  logic [7:0] in_byte,
  input  logic       flag,
  output logic [7:0] out_byte
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      else      p = p;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] affine_fwd(input logic [7:0] b);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] affine_inv(input logic [7:0] b);
    return rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05;
  endfunction

  // flag selects the inverse S-box
  always_comb begin
    if (flag) out_byte = gf_inv(affine_inv(in_byte));
    else      out_byte = affine_fwd(gf_inv(in_byte));
  end
endmodule

module key_expand_seq #(
  parameter int NK = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [32*NK-1:0] key_in,
  output logic            busy,
  output logic            rk_valid,
  input  logic            rk_ready,
  output logic [31:0]     rk_word,
  output logic [5:0]      rk_index,
  output logic            done
);
  localparam int         NW    = 4 * (NK + 7);
  localparam logic [5:0] LAST  = 6'(NW - 1);
  localparam logic [5:0] NK6   = 6'(NK);
  localparam logic [2:0] NK_M1 = 3'(NK - 1);

  if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
    $error("key_expand_seq: NK must be 4, 6 or 8");
  end

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  state_t      state_r;
  logic [31:0] win_r [NK];
  logic [2:0]  phase_r;   // (rk_index + 1) mod NK, i.e. position of the next word
  logic [7:0]  rcon_r;

  logic        xfer_s;
  logic        use_rcon_s;
  logic [5:0]  nidx_s;
  logic [31:0] prev_s, sub_in_s, sub_out_s, calc_s, key_word_s, next_word_s;

`ifdef KEXP_BACKPRESSURE_EN
  assign xfer_s = rk_valid & rk_ready;
`else
  logic unused_ready;
  assign unused_ready = rk_ready;
  assign xfer_s       = rk_valid;
`endif

  assign prev_s = win_r[NK-1];
  assign nidx_s = rk_index + 6'd1;

  // SubWord input: rotated on NK boundaries, raw on the AES-256 mid-key step
  always_comb begin
    if (phase_r == 3'd0) sub_in_s = {prev_s[23:0], prev_s[31:24]};
    else                 sub_in_s = prev_s;
  end

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    byte2S u_sbox (
      .in_byte  (sub_in_s[8*b +: 8]),
      .flag     (1'b0),
      .out_byte (sub_out_s[8*b +: 8])
    );
  end

  // Next schedule word: key words first, then the recurrence over the window
  always_comb begin
    use_rcon_s = 1'b0;
    calc_s     = win_r[0] ^ prev_s;
    if (phase_r == 3'd0) begin
      use_rcon_s = 1'b1;
      calc_s     = win_r[0] ^ sub_out_s ^ {rcon_r, 24'h000000};
    end else if ((NK == 8) && (phase_r == 3'd4)) begin
      calc_s     = win_r[0] ^ sub_out_s;
    end else begin
      calc_s     = win_r[0] ^ prev_s;
    end
    key_word_s = win_r[0];
    for (int k = 0; k < NK; k++) begin
      if (nidx_s == 6'(k)) key_word_s = win_r[k];
      else                 key_word_s = key_word_s;
    end
    if (nidx_s < NK6) next_word_s = key_word_s;
    else              next_word_s = calc_s;
  end

  // Control FSM, window shift register and registered stream outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      done     <= 1'b0;
      rk_word  <= 32'h00000000;
      rk_index <= 6'd0;
      rcon_r   <= 8'h01;
      phase_r  <= 3'd1;
      for (int k = 0; k < NK; k++) win_r[k] <= 32'h00000000;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            for (int k = 0; k < NK; k++) win_r[k] <= key_in[32*(NK-k)-1 -: 32];
            rk_word  <= key_in[32*NK-1 -: 32];
            rk_index <= 6'd0;
            rcon_r   <= 8'h01;
            phase_r  <= 3'd1;
            busy     <= 1'b1;
            rk_valid <= 1'b1;
            state_r  <= RUN;
          end
        end
        RUN: begin
          if (xfer_s) begin
            if (rk_index == LAST) begin
              state_r  <= IDLE;
              busy     <= 1'b0;
              rk_valid <= 1'b0;
              done     <= 1'b1;
            end else begin
              rk_index <= nidx_s;
              rk_word  <= next_word_s;
              phase_r  <= (phase_r == NK_M1) ? 3'd0 : phase_r + 3'd1;
              // key words are replayed in place; the window only moves once words are derived
              if (nidx_s >= NK6) begin
                for (int k = 0; k < NK - 1; k++) win_r[k] <= win_r[k+1];
                win_r[NK-1] <= calc_s;
                if (use_rcon_s) rcon_r <= xtime(rcon_r);
              end
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_key_expand_seq.sv
// Randomised bench for key_expand_seq (NK=4/6/8) against a FIPS-197 style schedule model.
module tb_key_expand_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         rk_ready;
  logic [2:0]   start_v;
  logic [255:0] kk;
  logic         busy4, valid4, done4, busy6, valid6, done6, busy8, valid8, done8;
  logic [31:0]  word4, word6, word8;
  logic [5:0]   index4, index6, index8;

  key_expand_seq #(.NK(4)) u_nk4 (.clk(clk), .rst_n(rst_n), .start(start_v[0]), .key_in(kk[255:128]),
    .busy(busy4), .rk_valid(valid4), .rk_ready(rk_ready), .rk_word(word4), .rk_index(index4), .done(done4));
  key_expand_seq #(.NK(6)) u_nk6 (.clk(clk), .rst_n(rst_n), .start(start_v[1]), .key_in(kk[255:64]),
    .busy(busy6), .rk_valid(valid6), .rk_ready(rk_ready), .rk_word(word6), .rk_index(index6), .done(done6));
  key_expand_seq #(.NK(8)) u_nk8 (.clk(clk), .rst_n(rst_n), .start(start_v[2]), .key_in(kk),
    .busy(busy8), .rk_valid(valid8), .rk_ready(rk_ready), .rk_word(word8), .rk_index(index8), .done(done8));

  int          sel;
  logic        m_busy, m_valid, m_done;
  logic [31:0] m_word;
  logic [5:0]  m_index;

  always_comb begin
    case (sel)
      1:       begin m_busy = busy6; m_valid = valid6; m_done = done6; m_word = word6; m_index = index6; end
      2:       begin m_busy = busy8; m_valid = valid8; m_done = done8; m_word = word8; m_index = index8; end
      default: begin m_busy = busy4; m_valid = valid4; m_done = done4; m_word = word4; m_index = index4; end
    endcase
  end

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  sb [256];
  logic [31:0] exp_w [60];
  logic [31:0] obs_w [60];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, want);
    end
  endtask

  // GF(2^8) product by carry-less multiply and reduction modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0000;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic build_schedule(input int nk);
    logic [7:0]  rc;
    logic [31:0] t;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) exp_w[i] = kk[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nk+7); i++) begin
      t = exp_w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      exp_w[i] = exp_w[i-nk] ^ t;
    end
  endtask

  task automatic launch(input bit hold);
    @(negedge clk);
    start_v[sel] = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start_v[sel] = 1'b0;
  endtask

  // Follows one schedule from the first word to the done pulse (or aborts by reset at abort_at)
  task automatic stream(input int nk, input bit stall, input int mid_start_at, input int abort_at, input bit keep);
    int idx, cyc, nw;
    bit fin, rdy;
    idx = 0; cyc = 0; fin = 1'b0; nw = 4*(nk+7);
    while (!fin && cyc < 2000 && n_errors < 40) begin
      @(negedge clk);
      cyc++;
      if (abort_at >= 0 && idx == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_eq("abort_valid", 32'(m_valid), 32'd0);
        check_eq("abort_busy",  32'(m_busy),  32'd0);
        check_eq("abort_done",  32'(m_done),  32'd0);
        check_eq("abort_word",  m_word,       32'd0);
        check_eq("abort_index", 32'(m_index), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      check_eq("valid", 32'(m_valid), 32'd1);
      check_eq("busy",  32'(m_busy),  32'd1);
      check_eq("index", 32'(m_index), 32'(idx));
      check_eq("word",  m_word,       exp_w[idx]);
      rdy = 1'b1;
`ifdef KEXP_BACKPRESSURE_EN
      if (stall) rdy = 1'($urandom_range(0, 1));
`endif
      rk_ready = rdy;
      if (!keep) start_v[sel] = (cyc == mid_start_at);
      if (m_valid && rdy) begin
        obs_w[idx] = m_word;
        if (idx == nw - 1) fin = 1'b1;
        else               idx++;
      end
    end
    check_eq("stream_complete", 32'(fin), 32'd1);
    if (!stall) check_eq("cycles", 32'(cyc), 32'(nw));
    @(negedge clk);
    check_eq("done_pulse", 32'(m_done),  32'd1);
    check_eq("done_busy",  32'(m_busy),  32'd0);
    check_eq("done_valid", 32'(m_valid), 32'd0);
    check_eq("word_hold",  m_word,       exp_w[nw-1]);
    if (!keep) begin
      @(negedge clk);
      check_eq("done_single", 32'(m_done),  32'd0);
      check_eq("idle_valid",  32'(m_valid), 32'd0);
    end
    rk_ready = 1'b1;
  endtask

  task automatic rand_key();
    for (int i = 0; i < 8; i++) kk[255 - 32*i -: 32] = $urandom;
  endtask

  initial begin
    rst_n = 1'b0; start_v = 3'b000; rk_ready = 1'b1; sel = 0;
    kk = 256'h0;
    build_sbox();
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check_eq("rst_valid", 32'(m_valid), 32'd0);
      check_eq("rst_busy",  32'(m_busy),  32'd0);
      check_eq("rst_done",  32'(m_done),  32'd0);
      check_eq("rst_word",  m_word,       32'd0);
      check_eq("rst_index", 32'(m_index), 32'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // AES-128 known vector, stray start mid-run
    sel = 0;
    kk = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    build_schedule(4);
    launch(1'b0);
    stream(4, 1'b0, 10, -1, 1'b0);
    check_eq("kat128_w4",  obs_w[4],  32'ha0fafe17);
    check_eq("kat128_w43", obs_w[43], 32'hb6630ca6);

    // AES-192 known vector
    sel = 1;
    kk = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    build_schedule(6);
    launch(1'b0);
    stream(6, 1'b0, -1, -1, 1'b0);
    check_eq("kat192_w6",  obs_w[6],  32'hfe0c91f7);
    check_eq("kat192_w51", obs_w[51], 32'h01002202);

    // AES-256 known vector
    sel = 2;
    kk = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    build_schedule(8);
    launch(1'b0);
    stream(8, 1'b0, -1, -1, 1'b0);
    check_eq("kat256_w8",  obs_w[8],  32'h9ba35411);
    check_eq("kat256_w12", obs_w[12], exp_w[12]);
    check_eq("kat256_w59", obs_w[59], 32'h706c631e);

    // random AES-128 key under (optional) back-pressure
    sel = 0;
    rand_key();
    build_schedule(4);
    launch(1'b0);
    stream(4, 1'b1, 7, -1, 1'b0);

    // reset at idx 20, then a full restart with the same key
    kk = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    build_schedule(4);
    launch(1'b0);
    stream(4, 1'b0, -1, 20, 1'b0);
    launch(1'b0);
    stream(4, 1'b0, -1, -1, 1'b0);
    check_eq("restart_w43", obs_w[43], 32'hb6630ca6);

    // start held across done: second schedule starts straight away
    sel = 1;
    rand_key();
    build_schedule(6);
    launch(1'b1);
    stream(6, 1'b0, -1, -1, 1'b1);
    stream(6, 1'b0, -1, -1, 1'b0);

    // random AES-192/256 keys with stalls
    for (int s = 1; s < 3; s++) begin
      sel = s;
      rand_key();
      build_schedule(s == 1 ? 6 : 8);
      launch(1'b0);
      stream(s == 1 ? 6 : 8, 1'b1, 5, -1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/key_expand_seq.md
# key_expand_seq

Sequential, word-serial AES key-expansion engine that generalises the single-word g-function step to full schedules for AES-128/192/256. Loads a cipher key on `start` and emits every schedule word w[0..4·(NK+7)−1] in order over a valid/ready stream. Sits between key-load logic and round-key storage/consumers in the cipher datapath. Uses the team's existing forward S-box byte module (`byte2S`, flag = 0), four instances, for SubWord.

## Interface
- `NK`, default 4: key length in 32-bit words; legal values 4, 6, 8 (AES-128/192/256). Any other value is an elaboration error.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin expansion; sampled only in IDLE.
- `key_in`  in  32·NK  cipher key, MSB-first: `key_in[32·NK−1 -: 32]` = w[0].
- `busy`  out  1  high from the cycle after accepted `start` until the final word transfers.
- `rk_valid`  out  1  `rk_word` holds a valid schedule word.
- `rk_ready`  in  1  consumer accepts the word (see Configuration).
- `rk_word`  out  32  schedule word w[rk_index].
- `rk_index`  out  6  index i of current word, 0..4·(NK+7)−1.
- `done`  out  1  one-cycle pulse after the last word transfers.

## Operation
- States: IDLE, RUN.
- IDLE: `start`=1 → latch `key_in` into NK-word window, idx←0, rcon←0x01, go RUN. `start` in RUN ignored.
- RUN: `rk_valid`=1. Word for idx<NK is key word idx; for idx≥NK it is computed combinationally from the window (window[0]=w[i−NK], window[NK−1]=w[i−1]):
  - i mod NK = 0: w[i−NK] ^ SubWord(RotWord(w[i−1])) ^ {rcon,24'h0}; RotWord = byte rotate left by 8.
  - NK=8 and i mod NK = 4: w[i−NK] ^ SubWord(w[i−1]).
  - else: w[i−NK] ^ w[i−1].
- Transfer = `rk_valid & rk_ready`. On transfer: window shifts by one word, new word enters at top; idx+1; if word used rcon, rcon←xtime(rcon) (0x80 → 0x1B).
- Transfer at idx = 4·(NK+7)−1 (43/51/59) → IDLE, `done`=1 next cycle.
- Reset (any state, asynchronous): IDLE; `busy`, `rk_valid`, `done`=0; `rk_word`, `rk_index`=0; rcon=0x01; window cleared. Reset mid-RUN abandons the schedule; no `done`.

## Timing
- `start` sampled at edge T → `busy`, `rk_valid` high from T+1 with w[0].
- Without stall: one word per cycle; last word at T+4·(NK+7); `done` pulse and `busy`=0 on the following cycle.
- `rk_word`/`rk_index` stable while `rk_valid & !rk_ready`.
- `start` in the `done` cycle (IDLE) is accepted; back-to-back schedules have one idle cycle between.
- `rk_word` outside RUN: holds last value (0 after reset); `rk_valid`=0.

## Configuration
- `KEXP_BACKPRESSURE_EN` defined: `rk_ready` honoured as above; stalls of any length allowed.
- Not defined: `rk_ready` ignored (treated as 1); one word every RUN cycle; consumer must always accept.

## Test plan
- NK=4, key 2b7e1516 28aed2a6 abf71588 09cf4f3c, rk_ready=1 → w[4]=a0fafe17, w[43]=b6630ca6, 44 words on consecutive cycles, `done` one cycle after w[43].
- NK=6, key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b → w[6]=fe0c91f7, w[51]=01002202.
- NK=8, key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4 → w[8]=9ba35411, w[12] uses SubWord-only path, w[59]=706c631e.
- With `KEXP_BACKPRESSURE_EN`, NK=4, random rk_ready (~50%) → identical 44-word sequence, word/index held during stalls; `start` pulsed mid-RUN ignored.
- rst_n asserted at idx=20, then new `start` with same key → outputs 0 immediately on reset; restart emits w[0] onward, full correct schedule, rcon restarted at 0x01.
- `start` held high across `done` → second schedule begins next cycle, identical words.
